// File: rtl/seg_scan_mux_if.sv
// Bundle of pattern inputs and display outputs for seg_scan_mux.
// master drives the patterns and control; slave is the scan driver.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7*NUM_DIGITS-1:0] digit_segs;
    logic [7*NUM_DIGITS-1:0] msg_segs;
    logic                    msg_sel;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_tick;

    modport master (
        output digit_segs, msg_segs, msg_sel, blank_mask,
        input  seg, an, frame_tick
    );

    modport slave (
        input  digit_segs, msg_segs, msg_sel, blank_mask,
        output seg, an, frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed common-anode 7-segment scan driver with live/message source selection.
// Optional message blinking is compiled in when SEG_BLINK_EN is defined.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic          clock,
    input  logic          reset_n,
    seg_scan_mux_if.slave bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0]         PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{1'b1}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    // Reject parameter sets that would break the guard-band timing.
    if (NUM_DIGITS < 2 || GUARD < 0 || SCAN_DIV < GUARD + 2 || BLINK_FRAMES < 1) begin : g_bad_params
        $error("seg_scan_mux: illegal parameter combination");
    end

    // Select the 7-bit pattern of digit k from a packed bus.
    function automatic logic [6:0] pick_digit(input logic [7*NUM_DIGITS-1:0] pats,
                                              input logic [IW-1:0]           k);
        logic [6:0] r;
        r = 7'h7F;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r = (k == IW'(i)) ? pats[7*i +: 7] : r;
        end
        return r;
    endfunction

    logic [PW-1:0]         pre_r;
    logic [IW-1:0]         idx_r;
    logic                  msg_lat_r;
    logic [6:0]            seg_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic                  frame_tick_r;

    logic                  slot_end_s;
    logic                  wrap_s;
    logic                  guard_s;
    logic                  dark_s;
    logic                  blank_s;
    logic [6:0]            src_s;
    logic [6:0]            seg_nxt_s;
    logic [NUM_DIGITS-1:0] an_nxt_s;

`ifdef SEG_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt_r;
    logic          phase_r;

    // Blink frame counter; a fresh message always starts in the visible phase.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcnt_r  <= {FW{1'b0}};
            phase_r <= 1'b0;
        end else if (wrap_s) begin
            if (bus.msg_sel && !msg_lat_r) begin
                fcnt_r  <= {FW{1'b0}};
                phase_r <= 1'b0;
            end else if (fcnt_r == FCNT_LAST) begin
                fcnt_r  <= {FW{1'b0}};
                phase_r <= ~phase_r;
            end else begin
                fcnt_r  <= fcnt_r + FW'(1);
                phase_r <= phase_r;
            end
        end else begin
            fcnt_r  <= fcnt_r;
            phase_r <= phase_r;
        end
    end

    assign dark_s = msg_lat_r & phase_r;
`else
    assign dark_s = 1'b0;
`endif

    // Slot/frame boundaries, guard band and next output values.
    always_comb begin
        slot_end_s = (pre_r == PRE_LAST);
        wrap_s     = slot_end_s && (idx_r == IDX_LAST);
        guard_s    = (32'(pre_r) < 32'(GUARD));
        blank_s    = guard_s | bus.blank_mask[idx_r] | dark_s;
        src_s      = msg_lat_r ? pick_digit(bus.msg_segs, idx_r)
                               : pick_digit(bus.digit_segs, idx_r);
        if (blank_s) begin
            an_nxt_s  = AN_OFF;
            seg_nxt_s = 7'h7F;
        end else begin
            an_nxt_s  = ~(AN_ONE << idx_r);
            seg_nxt_s = src_s;
        end
    end

    // Prescaler, digit index and frame-boundary message latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_r     <= {PW{1'b0}};
            idx_r     <= {IW{1'b0}};
            msg_lat_r <= 1'b0;
        end else if (slot_end_s) begin
            pre_r     <= {PW{1'b0}};
            idx_r     <= (idx_r == IDX_LAST) ? {IW{1'b0}} : idx_r + IW'(1);
            msg_lat_r <= wrap_s ? bus.msg_sel : msg_lat_r;
        end else begin
            pre_r     <= pre_r + PW'(1);
            idx_r     <= idx_r;
            msg_lat_r <= msg_lat_r;
        end
    end

    // Registered pin drivers; reset forces the display dark immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seg_r        <= 7'h7F;
            an_r         <= AN_OFF;
            frame_tick_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            an_r         <= an_nxt_s;
            frame_tick_r <= wrap_s;
        end
    end

    assign bus.seg        = seg_r;
    assign bus.an         = an_r;
    assign bus.frame_tick = frame_tick_r;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: time-based reference model plus literal spot checks.
module tb_seg_scan_mux;
    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int BF = 2;
    localparam int FL = SD * ND;
`ifdef SEG_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_mux #(
        .NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD), .BLINK_FRAMES(BF)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt;
    logic chk_en = 1'b0;

    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic       exp_ft;
    logic       mlat_m;
    int         lat_frame_m;

    // Display expected after the clock edge that ends cycle c (c edges since reset).
    function automatic logic [11:0] model_out(input int c, input logic mlat, input int latf,
                                              input logic [3:0] mask, input logic [27:0] dig,
                                              input logic [27:0] msg);
        int pre, idx, frame;
        logic dark, blk;
        logic [3:0] an;
        logic [6:0] sg;
        pre   = c % SD;
        idx   = (c / SD) % ND;
        frame = c / FL;
        dark  = BLINK && mlat && ((((frame - latf) / BF) % 2) == 1);
        blk   = (pre < GD) || mask[idx] || dark;
        an    = blk ? 4'hF : ~(4'b0001 << idx);
        sg    = blk ? 7'h7F : (mlat ? msg[7*idx +: 7] : dig[7*idx +: 7]);
        return {an, sg, ((c % FL) == FL - 1)};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exp_seg     <= 7'h7F;
            exp_an      <= 4'hF;
            exp_ft      <= 1'b0;
            mlat_m      <= 1'b0;
            lat_frame_m <= 0;
        end else begin
            {exp_an, exp_seg, exp_ft} <= model_out(edge_cnt, mlat_m, lat_frame_m, bus.blank_mask,
                                                   bus.digit_segs, bus.msg_segs);
            if ((edge_cnt % FL) == FL - 1) begin
                if (bus.msg_sel && !mlat_m) lat_frame_m <= edge_cnt / FL + 1;
                mlat_m <= bus.msg_sel;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model plus anode sanity.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_seg", 32'(bus.seg), 32'(exp_seg));
            chk("model_an", 32'(bus.an), 32'(exp_an));
            chk("model_frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
            chk("an_at_most_one_low", 32'($countones(~bus.an) <= 1), 32'd1);
        end
    end

    task automatic to_edge(input int n);
        int budget = 0;
        while (edge_cnt < n && budget < 2000) begin
            @(posedge clock);
            #1;
            budget++;
        end
        if (edge_cnt < n) begin
            checks++;
            errors++;
            $display("FAIL to_edge: reached %0d, wanted %0d", edge_cnt, n);
        end
    endtask

    task automatic spot(input string name, input logic [3:0] an_e, input logic [6:0] seg_e,
                        input logic ft_e);
        chk({name, "_an"}, 32'(bus.an), 32'(an_e));
        chk({name, "_seg"}, 32'(bus.seg), 32'(seg_e));
        chk({name, "_ft"}, 32'(bus.frame_tick), 32'(ft_e));
    endtask

    initial begin
        bus.digit_segs = {7'h40, 7'h79, 7'h24, 7'h30};
        bus.msg_segs   = {7'h0E, 7'h08, 7'h4F, 7'h47};
        bus.msg_sel    = 1'b0;
        bus.blank_mask = 4'b0000;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        #1 spot("reset_hold", 4'hF, 7'h7F, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Live scan: digit 0 first, one guard cycle per slot.
        to_edge(1);  spot("d0_guard", 4'hF, 7'h7F, 1'b0);
        to_edge(2);  spot("d0_lit", 4'hE, 7'h30, 1'b0);
        to_edge(6);  spot("d1_lit", 4'hD, 7'h24, 1'b0);
        to_edge(16); spot("wrap_tick", 4'h7, 7'h40, 1'b1);
        to_edge(17); spot("after_tick", 4'hF, 7'h7F, 1'b0);

        // Message requested mid-frame takes effect only after the wrap.
        to_edge(22); bus.msg_sel = 1'b1;
        to_edge(30); spot("msg_pending", 4'h7, 7'h40, 1'b0);
        to_edge(34); spot("msg_d0", 4'hE, 7'h47, 1'b0);

        // Blank digit 2 live.
        to_edge(48); bus.blank_mask = 4'b0100;
        to_edge(54); spot("mask_d1", 4'hD, 7'h4F, 1'b0);
        to_edge(58); spot("mask_d2", 4'hF, 7'h7F, 1'b0);
        to_edge(60); bus.blank_mask = 4'b0000;

        // Message kept on: steady, or 2 visible / 2 dark frames when blinking.
        to_edge(66);
        if (BLINK) spot("blink_dark1", 4'hF, 7'h7F, 1'b0);
        else       spot("steady_f4", 4'hE, 7'h47, 1'b0);
        to_edge(98); spot("msg_f6", 4'hE, 7'h47, 1'b0);
        to_edge(130);
        if (BLINK) spot("blink_dark2", 4'hF, 7'h7F, 1'b0);
        else       spot("steady_f8", 4'hE, 7'h47, 1'b0);
        to_edge(140); bus.msg_sel = 1'b0;
        to_edge(146); spot("live_again", 4'hE, 7'h30, 1'b0);

        // Reset in the middle of a lit slot.
        to_edge(150);
        #1 reset_n = 1'b0;
        #1 spot("midslot_reset", 4'hF, 7'h7F, 1'b0);
        repeat (2) @(negedge clock);
        bus.digit_segs = {7'h12, 7'h02, 7'h78, 7'h00};
        reset_n = 1'b1;
        to_edge(2); spot("restart_d0", 4'hE, 7'h00, 1'b0);
        bus.digit_segs[6:0] = 7'h66;
        to_edge(3); spot("pattern_update", 4'hE, 7'h66, 1'b0);
        to_edge(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
